// File: rtl/pedal_pkg.sv
// rtl/pedal_pkg.sv - shared types and constants for the tap scheduler
//
// Purpose: FSM state encoding, fixed-point constants and the accumulator
// width function shared by sram_tap_scheduler and tap_mac.
// Ports: none (package).
package pedal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int          FRAC_BITS = 15;
    localparam logic [15:0] SAT_MAX   = 16'h7FFF;
    localparam logic [15:0] SAT_MIN   = 16'h8000;
    localparam int          PROD_W    = 32;

    // Wide enough for the dry product plus one product per tap without wrap.
    function automatic int acc_width(input int num_taps);
        return PROD_W + $clog2(num_taps + 1);
    endfunction

endpackage

// File: rtl/sram_tap_scheduler_if.sv
// rtl/sram_tap_scheduler_if.sv - single-port sample SRAM bus
//
// Purpose: groups the SRAM macro port driven by the scheduler.
// Signals: mem_en/mem_we/mem_addr/mem_wdata (master -> SRAM),
//          mem_rdata (SRAM -> master, valid one cycle after a read).
// Modports: master (scheduler), slave (SRAM macro or model).
interface sram_tap_scheduler_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/tap_mac.sv
// rtl/tap_mac.sv - signed multiply-accumulate with saturating Q1.15 output
//
// Purpose: one signed DATA_W x 16 multiplier feeding a non-wrapping
// accumulator, plus the arithmetic-shift/saturate output stage.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears accumulator)
//   load_i      acc <= a*b (starts a new sample with the dry product)
//   acc_en_i    acc <= acc + a*b
//   a_i, b_i    signed operands (sample, Q1.15 gain)
//   sat_o       sat16((acc + a*b) >>> FRAC_BITS), i.e. the result including
//               the product presented this cycle
module tap_mac
    import pedal_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = acc_width(4)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_i,
    input  logic                     acc_en_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [15:0]       b_i,
    output logic signed [DATA_W-1:0] sat_o
);

    localparam int PW = DATA_W + 16;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_shift;
    logic                    ovf;

    assign prod     = a_i * b_i;
    assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    assign acc_sum  = acc_q + prod_ext;

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = prod_ext;
        end else if (acc_en_i) begin
            acc_d = acc_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Out of range whenever the bits above the output sign bit are not all
    // copies of it.
    assign acc_shift = acc_sum >>> FRAC_BITS;
    assign ovf       = (acc_shift[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){1'b0}}) &&
                       (acc_shift[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){1'b1}});

    always_comb begin
        sat_o = acc_shift[DATA_W-1:0];
        if (ovf) begin
            sat_o = acc_shift[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/sram_tap_scheduler.sv
// rtl/sram_tap_scheduler.sv - per-sample SRAM write + multi-tap read sequencer
//
// Purpose: on each accepted sample strobe, write the sample into a circular
// delay buffer, read NUM_TAPS taps at programmable delays, weight and sum
// them with the dry path and emit one saturated output sample.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   sample_strobe     one-cycle sample tick (already synchronous)
//   sample_in         signed input sample, latched on an accepted strobe
//   record_en         1 = write sample to buffer, 0 = freeze/loop buffer
//   dry_gain          Q1.15 gain on sample_in
//   tap_delay         flattened per-tap delays in samples
//   tap_gain          flattened per-tap Q1.15 gains
//   mem               SRAM master port
//   sample_out        saturated result, held until the next result
//   sample_out_valid  one-cycle pulse when sample_out updates
//   busy              high while a sequence is in flight
//   overrun           sticky, set by a strobe while busy
//   overrun_clr       synchronous clear of overrun (a same-cycle set wins)
module sram_tap_scheduler
    import pedal_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int NUM_TAPS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_strobe,
    input  logic signed [DATA_W-1:0]   sample_in,
    input  logic                       record_en,
    input  logic signed [15:0]         dry_gain,
    input  logic [NUM_TAPS*ADDR_W-1:0] tap_delay,
    input  logic [NUM_TAPS*16-1:0]     tap_gain,
    sram_tap_scheduler_if.master       mem,
    output logic signed [DATA_W-1:0]   sample_out,
    output logic                       sample_out_valid,
    output logic                       busy,
    output logic                       overrun,
    input  logic                       overrun_clr
);

    localparam int             KW     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int             ACC_W  = acc_width(NUM_TAPS);
    localparam logic [KW-1:0]  K_LAST = KW'(NUM_TAPS - 1);

    state_t                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic                     mem_en_q, mem_en_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d;
    logic signed [DATA_W-1:0] sample_out_q, sample_out_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;
    logic                     overrun_q, overrun_d;

    logic                     mac_load;
    logic                     mac_acc;
    logic [KW-1:0]            gain_idx;
    logic [ADDR_W-1:0]        rd_delay;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [15:0]       mac_b;
    logic signed [DATA_W-1:0] mac_sat;

    // State register process: FSM, counters and every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            wr_ptr_q     <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            sample_out_q <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            wr_ptr_q     <= wr_ptr_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            sample_out_q <= sample_out_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state process.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        wr_ptr_d = wr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (sample_strobe) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_READ;
                k_d     = '0;
            end
            ST_READ: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d  = ST_IDLE;
                // Advances even when frozen so a frozen buffer loops.
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output process. SRAM controls are computed for the state being
    // entered so they are registered and line up with that state's cycle.
    // The MAC works on the current state: read data for tap k-1 arrives
    // in READ cycle k, and the last tap's data arrives in DRAIN.
    always_comb begin
        rd_delay     = tap_delay[k_d*ADDR_W +: ADDR_W];
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        case (state_d)
            ST_WRITE: begin
                mem_en_d    = record_en;
                mem_we_d    = record_en;
                mem_addr_d  = wr_ptr_q;
                mem_wdata_d = sample_in;
            end
            ST_READ: begin
                mem_en_d   = 1'b1;
                mem_addr_d = wr_ptr_q - rd_delay;
            end
            default: begin
            end
        endcase

        mac_load = sample_strobe && (state_q == ST_IDLE);
        mac_acc  = ((state_q == ST_READ) && (k_q != '0)) || (state_q == ST_DRAIN);
        gain_idx = (state_q == ST_DRAIN) ? K_LAST : (k_q - 1'b1);
        if (state_q == ST_IDLE) begin
            mac_a = sample_in;
            mac_b = dry_gain;
        end else begin
            mac_a = $signed(mem.mem_rdata);
            mac_b = $signed(tap_gain[gain_idx*16 +: 16]);
        end

        valid_d      = (state_q == ST_DRAIN);
        sample_out_d = (state_q == ST_DRAIN) ? mac_sat : sample_out_q;
        busy_d       = (state_d != ST_IDLE);

        overrun_d = overrun_q;
        if (sample_strobe && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    tap_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_tap_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (mac_load),
        .acc_en_i (mac_acc),
        .a_i      (mac_a),
        .b_i      (mac_b),
        .sat_o    (mac_sat)
    );

    assign mem.mem_en       = mem_en_q;
    assign mem.mem_we       = mem_we_q;
    assign mem.mem_addr     = mem_addr_q;
    assign mem.mem_wdata    = mem_wdata_q;
    assign sample_out       = sample_out_q;
    assign sample_out_valid = valid_q;
    assign busy             = busy_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_sram_tap_scheduler.sv
// tb/tb_sram_tap_scheduler.sv - scoreboard bench for sram_tap_scheduler
module tb_sram_tap_scheduler;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 16;
    localparam int NUM_TAPS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst_n         = 1'b0;
    logic                       sample_strobe = 1'b0;
    logic [15:0]                sample_in     = '0;
    logic                       record_en     = 1'b1;
    logic [15:0]                dry_gain      = '0;
    logic                       overrun_clr   = 1'b0;
    logic [ADDR_W-1:0]          dly [NUM_TAPS];
    logic [15:0]                gn  [NUM_TAPS];
    logic [NUM_TAPS*ADDR_W-1:0] tap_delay;
    logic [NUM_TAPS*16-1:0]     tap_gain;
    logic [15:0]                sample_out;
    logic                       sample_out_valid;
    logic                       busy;
    logic                       overrun;

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_flat
        assign tap_delay[g*ADDR_W +: ADDR_W] = dly[g];
        assign tap_gain[g*16 +: 16]          = gn[g];
    end

    sram_tap_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    sram_tap_scheduler #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_TAPS (NUM_TAPS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_strobe    (sample_strobe),
        .sample_in        (sample_in),
        .record_en        (record_en),
        .dry_gain         (dry_gain),
        .tap_delay        (tap_delay),
        .tap_gain         (tap_gain),
        .mem              (mem_if),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .busy             (busy),
        .overrun          (overrun),
        .overrun_clr      (overrun_clr)
    );

    // SRAM model: synchronous write, registered read.
    logic [15:0] sram [1024] = '{default: 16'h0000};
    logic [15:0] rd_data = '0;
    always @(posedge clk) begin
        if (mem_if.mem_en) begin
            if (mem_if.mem_we) sram[mem_if.mem_addr] <= mem_if.mem_wdata;
            else               rd_data <= sram[mem_if.mem_addr];
        end
    end
    assign mem_if.mem_rdata = rd_data;

    int vectors    = 0;
    int miscompares = 0;
    int exp_wr     = 0;

    logic [15:0] out_q [$];
    logic [25:0] wr_q  [$];
    logic [9:0]  rd_e  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an output.
    logic       prev_rd  = 1'b0;
    logic [9:0] first_rd = '0;
    logic [9:0] last_wr  = '0;
    int         we_seen  = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (sample_out_valid) begin
                if (out_q.size() == 0) check("unexpected_valid", 1, 0);
                else                   check("sample_out", sample_out, out_q.pop_front());
            end
            if (mem_if.mem_en && mem_if.mem_we) begin
                we_seen <= we_seen + 1;
                last_wr <= mem_if.mem_addr;
                if (wr_q.size() == 0) check("unexpected_write", 1, 0);
                else check("write_addr_data", {mem_if.mem_addr, mem_if.mem_wdata}, wr_q.pop_front());
            end
            if (mem_if.mem_en && !mem_if.mem_we) begin
                if (!prev_rd) first_rd <= mem_if.mem_addr;
                if (rd_e.size() == 0) check("unexpected_read", 1, 0);
                else                  check("read_addr", mem_if.mem_addr, rd_e.pop_front());
            end
            prev_rd <= mem_if.mem_en && !mem_if.mem_we;
        end else begin
            prev_rd <= 1'b0;
        end
    end

    task automatic push_expect(input logic [15:0] s, input logic [15:0] exp_out);
        if (record_en) wr_q.push_back({10'(exp_wr), s});
        for (int k = 0; k < NUM_TAPS; k++) rd_e.push_back(10'(exp_wr) - dly[k]);
        out_q.push_back(exp_out);
    endtask

    // Entered and left at posedge+1; strobes are 7 cycles apart.
    task automatic run_sample(input logic [15:0] s, input logic [15:0] exp_out, input bit chk_lat);
        push_expect(s, exp_out);
        sample_in     = s;
        sample_strobe = 1'b1;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (chk_lat) check("valid_latency", sample_out_valid, (i == 6) ? 1 : 0);
        end
        exp_wr = (exp_wr + 1) % 1024;
    endtask

    // Second strobe lands 2 cycles after the first, optionally with overrun_clr.
    task automatic run_overrun(input logic [15:0] s, input logic [15:0] exp_out, input bit clr_with);
        push_expect(s, exp_out);
        sample_in     = s;
        sample_strobe = 1'b1;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        @(posedge clk); #1;
        sample_strobe = 1'b1;
        overrun_clr   = clr_with;
        sample_in     = 16'hFFFF;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        overrun_clr   = 1'b0;
        check("overrun_set", overrun, 1);
        check("busy_in_flight", busy, 1);
        for (int i = 3; i <= 6; i++) begin
            @(posedge clk); #1;
        end
        exp_wr = (exp_wr + 1) % 1024;
    endtask

    task automatic pulse_clr();
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    int snap;

    initial begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            dly[k] = '0;
            gn[k]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_en", mem_if.mem_en, 0);
        check("reset_mem_we", mem_if.mem_we, 0);
        check("reset_busy", busy, 0);
        check("reset_sample_out", sample_out, 0);
        check("reset_valid", sample_out_valid, 0);
        check("reset_overrun", overrun, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Echo configuration, used also for the aborted sequence.
        dly[0] = 10'd3; dly[1] = 10'd1; dly[2] = 10'd2; dly[3] = 10'd4;
        gn[0]  = 16'h4000;

        // Reset two cycles into a sequence.
        wr_q.push_back({10'd0, 16'h0000});
        rd_e.push_back(10'd0 - dly[0]);
        sample_in     = 16'h0000;
        sample_strobe = 1'b1;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_mem_en", mem_if.mem_en, 0);
        check("abort_mem_we", mem_if.mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_sample_out", sample_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_pending", out_q.size() + wr_q.size() + rd_e.size(), 0);

        // Echo: tap0 delay 3, gain 0.5.
        run_sample(16'h4000, 16'h0000, 0);
        check("first_write_after_reset", last_wr, 0);
        run_sample(16'h0000, 16'h0000, 0);
        run_sample(16'h0000, 16'h0000, 0);
        run_sample(16'h0000, 16'h2000, 0);

        // Dry path with latency check.
        gn[0]    = 16'h0000;
        dry_gain = 16'h4000;
        run_sample(16'h2000, 16'h1000, 1);

        // Delay 0 reads the sample written in the same sequence.
        dry_gain = 16'h0000;
        dly[0]   = 10'd0;
        gn[0]    = 16'h4000;
        run_sample(16'h4000, 16'h2000, 0);

        // Saturation high then low.
        gn[0] = 16'h0000;
        for (int k = 0; k < NUM_TAPS; k++) dly[k] = 10'(k);
        for (int i = 0; i < 3; i++) run_sample(16'h7FFF, 16'h0000, 0);
        dry_gain = 16'h7FFF;
        for (int k = 0; k < NUM_TAPS; k++) gn[k] = 16'h7FFF;
        run_sample(16'h7FFF, 16'h7FFF, 0);
        dry_gain = 16'h0000;
        for (int k = 0; k < NUM_TAPS; k++) gn[k] = 16'h0000;
        for (int i = 0; i < 3; i++) run_sample(16'h8000, 16'h0000, 0);
        dry_gain = 16'h7FFF;
        for (int k = 0; k < NUM_TAPS; k++) gn[k] = 16'h7FFF;
        run_sample(16'h8000, 16'h8000, 0);
        dry_gain = 16'h0000;
        for (int k = 0; k < NUM_TAPS; k++) gn[k] = 16'h0000;

        // Overrun: sticky until cleared; set wins over a same-cycle clear.
        run_overrun(16'h1234, 16'h0000, 0);
        @(posedge clk); #1;
        check("overrun_sticky", overrun, 1);
        pulse_clr();
        check("overrun_cleared", overrun, 0);
        run_overrun(16'h0000, 16'h0000, 1);
        pulse_clr();
        check("overrun_cleared2", overrun, 0);

        // Freeze: no writes, old content looped, pointer still advances.
        snap      = we_seen;
        record_en = 1'b0;
        dly[0]    = 10'd2;
        gn[0]     = 16'h4000;
        run_sample(16'h5555, 16'h091A, 0);
        run_sample(16'h5555, 16'h0000, 0);
        run_sample(16'h5555, 16'h0000, 0);
        check("freeze_no_we", we_seen - snap, 0);
        record_en = 1'b1;
        gn[0]     = 16'h0000;
        run_sample(16'h0000, 16'h0000, 0);
        check("freeze_ptr_advanced", last_wr, 19);

        // Wrap of the write pointer and of the read address.
        dly[0] = 10'd5;
        while (exp_wr != 1020) run_sample(16'h0000, 16'h0000, 0);
        run_sample(16'h0000, 16'h0000, 0);
        check("wrap_rd_1015", first_rd, 1015);
        run_sample(16'h0000, 16'h0000, 0);
        run_sample(16'h0000, 16'h0000, 0);
        run_sample(16'h0000, 16'h0000, 0);
        check("wrap_wr_1023", last_wr, 1023);
        run_sample(16'h0000, 16'h0000, 0);
        check("wrap_wr_0", last_wr, 0);
        run_sample(16'h0000, 16'h0000, 0);
        run_sample(16'h0000, 16'h0000, 0);
        check("wrap_rd_1021", first_rd, 1021);

        repeat (5) @(posedge clk);
        #1;
        check("drain_out_q", out_q.size(), 0);
        check("drain_wr_q", wr_q.size(), 0);
        check("drain_rd_q", rd_e.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_tap_scheduler.md
Name: sram_tap_scheduler

Overview:
- Sequences the single-port on-chip sample SRAM once per ADC sample: one record write into a circular delay buffer, then NUM_TAPS tap reads at programmable delays.
- Each tap read is multiplied by a per-tap gain and accumulated with a dry path. The block emits one saturated output sample per sample strobe.
- Sits between the ADC sample tick / effect-config registers and the SRAM macro. It is the only master of the SRAM port.

Parameters:
- ADDR_W, 10, SRAM address width; buffer depth is 2**ADDR_W words.
- DATA_W, 16, sample width (signed Q1.15).
- NUM_TAPS, 4, number of delay taps read per sample (1..8).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sample_strobe  in  1  one-cycle pulse, already synchronised to clk, one per ADC sample.
- sample_in  in  DATA_W  signed input sample; latched on the accepted strobe.
- record_en  in  1  1 = write sample_in to the buffer; 0 = freeze/loop the buffer.
- dry_gain  in  16  signed Q1.15 gain on sample_in.
- tap_delay  in  NUM_TAPS*ADDR_W  flattened; tap k uses bits [k*ADDR_W +: ADDR_W], delay in samples.
- tap_gain  in  NUM_TAPS*16  flattened signed Q1.15 gains.
- mem_en  out  1  SRAM access enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after a read is issued.
- sample_out  out  DATA_W  saturated signed result; held until the next result.
- sample_out_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high while the FSM is not in IDLE.
- overrun  out  1  sticky; set when a strobe arrives while busy.
- overrun_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset, asynchronous, while rst_n = 0:
  - All outputs are 0.
  - wr_ptr = 0, FSM = IDLE, accumulator = 0.
  - SRAM contents are untouched.
  - Reset mid-sequence aborts the sequence; no valid pulse is produced for it.
- FSM states: IDLE, WRITE, READ, DRAIN. All outputs are registered.
- IDLE:
  - On sample_strobe: latch sample_in, load acc = sample_in*dry_gain (sign-extended), go to WRITE.
  - With no strobe: mem_en = 0.
- WRITE (1 cycle):
  - mem_addr = wr_ptr, mem_wdata = latched sample.
  - mem_en = mem_we = record_en. When record_en = 0 no access occurs, but the cycle is still spent, so timing is fixed.
  - Next state: READ with k = 0.
- READ (NUM_TAPS cycles):
  - In cycle k: mem_en = 1, mem_we = 0, mem_addr = (wr_ptr - tap_delay[k]) mod 2**ADDR_W.
  - From k >= 1, accumulate mem_rdata*tap_gain[k-1].
  - After k = NUM_TAPS-1, go to DRAIN.
- DRAIN (1 cycle):
  - mem_en = 0; accumulate mem_rdata*tap_gain[NUM_TAPS-1].
  - On exit: sample_out = sat16(acc >>> 15), sample_out_valid = 1 for one cycle, wr_ptr += 1 (wraps 2**ADDR_W-1 -> 0), go to IDLE.
- Latency: sample_out_valid is high in the cycle NUM_TAPS+2 clocks after the edge that sampled the strobe (6 for the defaults).
  - Minimum strobe spacing is NUM_TAPS+3 cycles.
- Arithmetic:
  - Products are Q2.30, 32-bit signed.
  - Accumulator is 32+clog2(NUM_TAPS+1) bits; it never wraps.
  - Output shift is arithmetic by 15.
  - Saturation clamps to 0x7FFF / 0x8000.
- Delay 0 reads the sample written in the same sequence (write precedes read). With record_en = 0 it reads the old content.
- wr_ptr advances regardless of record_en, so a frozen buffer loops with period 2**ADDR_W.
- Strobe while busy:
  - The strobe is ignored and overrun is set.
  - The in-flight sequence completes normally.
  - If overrun_clr and a new overrun event occur in the same cycle, set wins.
- tap_delay, tap_gain and dry_gain are read live and must be quasi-static. A change during READ affects only taps not yet issued.

Decomposition:
- Shared package (pedal_pkg) holds:
  - FSM state encoding.
  - FRAC_BITS = 15.
  - SAT_MAX = 16'h7FFF, SAT_MIN = 16'h8000.
  - Accumulator width function.
- One sub-module, tap_mac: signed 16x16 multiply, accumulate with load/clear, and a saturating Q1.15 output stage.
- The FSM and address generation stay in sram_tap_scheduler.

Test Plan:
- Reset: assert rst_n = 0 two cycles after a strobe -> mem_en/mem_we/busy/sample_out go 0 immediately; no sample_out_valid pulse; after release, the next strobe writes to address 0.
- Dry path: dry_gain = 0x4000, all tap_gain = 0, sample_in = 0x2000 -> write at addr 0 with data 0x2000; sample_out = 0x1000 with valid 6 cycles after the strobe; 4 reads at addr 0 - delay.
- Echo: dry_gain = 0, tap0 delay = 3 gain = 0x4000, other gains 0; inputs 0x4000, 0, 0, 0 -> outputs 0, 0, 0, 0x2000.
- Wrap: after 1020 strobes (wr_ptr = 1020), tap0 delay = 5 -> mem_addr 1015; after 1026 strobes (wr_ptr = 2) -> mem_addr 1021; wr_ptr 1023 -> 0.
- Saturation: buffer filled with 0x7FFF, dry and all tap gains 0x7FFF -> sample_out = 0x7FFF; buffer filled with 0x8000, same gains -> 0x8000.
- Overrun and freeze:
  - Second strobe 2 cycles after the first -> exactly one valid pulse, overrun = 1 until overrun_clr.
  - record_en = 0 -> mem_we never asserts, and wr_ptr still increments per strobe.
